// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - main-memory line responder with fixed access latency
module data_memory_responder #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int LINE_W  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} stateType;

  stateType          state;
  logic [7:0]        counter;
  logic              latWrite;
  logic [26:0]       latIdx;
  logic [LINE_W-1:0] latData;

  logic [LINE_W-1:0] mem [DEPTH];

  logic              reqWrite;
  logic [26:0]       reqIdx;
  logic [LINE_W-1:0] reqData;
  logic              inRange;
  logic              enterAck;
  logic              commitWrite;
  logic [IDX_W-1:0]  memIdx;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^addr_i[4:0];

  // With LATENCY=1 the commit happens on the acceptance edge itself, so the
  // live request fields are used in IDLE and the latched copy everywhere else.
  always_comb begin
    reqWrite = latWrite;
    reqIdx   = latIdx;
    reqData  = latData;
    if (state == IDLE) begin
      reqWrite = write_i;
      reqIdx   = addr_i[31:5];
      reqData  = data_i;
    end
    inRange     = reqIdx < 27'(DEPTH);
    enterAck    = ((state == IDLE) && enable_i && (LATENCY == 1)) ||
                  ((state == WAIT) && (counter == 8'd1));
    commitWrite = enterAck && reqWrite && inRange;
    memIdx      = reqIdx[IDX_W-1:0];
  end

  // Array is not reset; a reset landing on the commit edge still commits.
  always_ff @(posedge clk_i) begin
    if (commitWrite) begin
      mem[memIdx] <= reqData;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      counter  <= 8'd0;
      latWrite <= 1'b0;
      latIdx   <= '0;
      latData  <= '0;
      ack_o    <= 1'b0;
      data_o   <= '0;
      busy_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_i) begin
            latWrite <= write_i;
            latIdx   <= addr_i[31:5];
            latData  <= data_i;
            counter  <= LAT_M1;
            busy_o   <= 1'b1;
            state    <= (LATENCY == 1) ? ACK : WAIT;
          end
        end
        WAIT: begin
          counter <= counter - 8'd1;
          if (counter == 8'd1) begin
            state <= ACK;
          end
        end
        ACK: begin
          state  <= IDLE;
          ack_o  <= 1'b0;
          err_o  <= 1'b0;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (enterAck) begin
        ack_o <= 1'b1;
        if (inRange) begin
          if (!reqWrite) begin
            data_o <= mem[memIdx];
          end
        end else begin
          err_o <= 1'b1;
          if (!reqWrite) begin
            data_o <= '0;
          end
        end
      end
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i && (state == IDLE)) begin
      assert (!$isunknown(enable_i));
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed bench for data_memory_responder
module tb_data_memory_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         en = 1'b0, wr = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] din = '0;
  logic         ack, busy, err;
  logic [255:0] dout;

  logic         en1 = 1'b0, wr1 = 1'b0;
  logic [31:0]  addr1 = '0;
  logic [255:0] din1 = '0;
  logic         ack1, busy1, err1;
  logic [255:0] dout1;

  int tests = 0;
  int failed = 0;
  int edges, busyCnt, ackCnt;

  localparam logic [255:0] LINE_A5 = {32{8'hA5}};
  localparam logic [255:0] PAT     = {8{32'h1234_5678}};
  localparam logic [255:0] Q0      = {4{64'hCAFE_F00D_0BAD_BEEF}};
  localparam logic [255:0] R88     = {16{16'hBEEF}};
  localparam logic [255:0] OLD7    = {8{32'h0707_0707}};
  localparam logic [255:0] NEW7    = {8{32'hFFFF_0000}};
  localparam logic [255:0] S1      = {32{8'h3C}};

  always #5 clk = ~clk;

  data_memory_responder #(.LATENCY(10)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .write_i(wr), .addr_i(addr),
    .data_i(din), .ack_o(ack), .data_o(dout), .busy_o(busy), .err_o(err)
  );

  data_memory_responder #(.LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en1), .write_i(wr1), .addr_i(addr1),
    .data_i(din1), .ack_o(ack1), .data_o(dout1), .busy_o(busy1), .err_o(err1)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [255:0] d);
    en = 1'b1; wr = w; addr = a; din = d;
  endtask

  task automatic waitAck(output int nEdges, output int nBusy);
    nEdges = 0;
    nBusy = 0;
    do begin
      @(posedge clk); #1;
      nEdges++;
      if (busy) nBusy++;
    end while (!ack && nEdges < 60);
  endtask

  initial begin
    #1;
    check("reset_ack", ack, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_data", dout, 0);
    check("reset_ack_l1", ack1, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1 latency
    dut.mem[4] = LINE_A5;
    drive(1'b0, 32'h80, '0);
    waitAck(edges, busyCnt);
    en = 1'b0;
    check("t1_latency", edges, 10);
    check("t1_busy_cycles", busyCnt, 10);
    check("t1_data", dout, LINE_A5);
    check("t1_err", err, 0);
    @(posedge clk); #1;
    check("t1_ack_drop", ack, 0);
    check("t1_busy_drop", busy, 0);
    check("t1_data_hold", dout, LINE_A5);

    // T2 write then read with ignored offset
    drive(1'b1, 32'h200, PAT);
    waitAck(edges, busyCnt);
    en = 1'b0;
    check("t2_wr_latency", edges, 10);
    check("t2_wr_err", err, 0);
    check("t2_wr_data_unchanged", dout, LINE_A5);
    @(posedge clk); #1;
    drive(1'b0, 32'h21F, '0);
    waitAck(edges, busyCnt);
    en = 1'b0;
    check("t2_rd_data", dout, PAT);
    check("t2_rd_err", err, 0);
    @(posedge clk); #1;

    // T3 back-to-back: read re-asserted right after the write ack
    drive(1'b1, 32'h0, Q0);
    waitAck(edges, busyCnt);
    drive(1'b0, 32'h0, '0);
    waitAck(edges, busyCnt);
    en = 1'b0;
    check("t3_ack_spacing", edges, 11);
    check("t3_busy_cycles", busyCnt, 10);
    check("t3_rd_data", dout, Q0);
    @(posedge clk); #1;

    // T4 out of range read and write; idx 600 aliases line 88 if decoded wrong
    dut.mem[88] = R88;
    drive(1'b0, 32'h0000_4000, '0);
    waitAck(edges, busyCnt);
    en = 1'b0;
    check("t4_rd_ack", ack, 1);
    check("t4_rd_err", err, 1);
    check("t4_rd_data", dout, 0);
    @(posedge clk); #1;
    check("t4_err_drop", err, 0);
    drive(1'b1, 32'h0000_4B00, {8{32'hDEAD_DEAD}});
    waitAck(edges, busyCnt);
    en = 1'b0;
    check("t4_wr_err", err, 1);
    check("t4_wr_data_unchanged", dout, 0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, '0);
    waitAck(edges, busyCnt);
    en = 1'b0;
    check("t4_line0", dout, Q0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0B00, '0);
    waitAck(edges, busyCnt);
    en = 1'b0;
    check("t4_line88", dout, R88);
    @(posedge clk); #1;

    // T5 reset during a pending write
    dut.mem[7] = OLD7;
    drive(1'b1, 32'hE0, NEW7);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    en = 1'b0;
    rst = 1'b1;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ack", ack, 0);
    check("t5_rst_data", dout, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ackCnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ack) ackCnt++;
    end
    check("t5_no_ack", ackCnt, 0);
    drive(1'b0, 32'hE0, '0);
    waitAck(edges, busyCnt);
    en = 1'b0;
    check("t5_line7_old", dout, OLD7);
    @(posedge clk); #1;

    // T6 LATENCY=1 build
    dut1.mem[1] = S1;
    en1 = 1'b1; wr1 = 1'b0; addr1 = 32'h20;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!ack1 && edges < 20);
    en1 = 1'b0;
    check("t6_l1_latency", edges, 1);
    check("t6_l1_data", dout1, S1);
    check("t6_l1_busy", busy1, 1);
    @(posedge clk); #1;
    check("t6_l1_ack_drop", ack1, 0);

    // T6 enable dropped during WAIT still completes exactly once
    drive(1'b0, 32'h80, '0);
    @(posedge clk); #1;
    en = 1'b0;
    addr = 32'h200;
    ackCnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (ack) begin
        ackCnt++;
        check("t6_drop_data", dout, LINE_A5);
      end
      @(posedge clk); #1;
    end
    check("t6_drop_one_ack", ackCnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
